// File: rtl/desim_pixel_painter.sv
// DESim plot bridge: one plot pulse per new pixel coordinate, colour chosen by mode
// (solid, bars, checker, or VGA-core pass-through). Optional macro DESIM_BORDER_OVERLAY_EN.
module desim_pixel_painter #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int CH_W        = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CHECK_SHIFT = 5,
    parameter int TIMEOUT     = 16,
    localparam int COLOR_W    = 3 * CH_W,
    parameter logic [COLOR_W-1:0] ERR_COLOR    = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}},
    parameter logic [COLOR_W-1:0] BORDER_COLOR = {COLOR_W{1'b1}}
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] solid_color,
    input  logic [X_W-1:0]     VGA_X,
    input  logic [Y_W-1:0]     VGA_Y,
    output logic               px_req,
    output logic [X_W-1:0]     px_x,
    output logic [Y_W-1:0]     px_y,
    input  logic [COLOR_W-1:0] px_color,
    input  logic               px_valid,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         frame_count
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [X_W+Y_W-1:0] FRAME_END = {X_W'(H_ACTIVE - 1), Y_W'(V_ACTIVE - 1)};

    typedef enum logic [1:0] {IDLE, WAIT, PLOT} state_t;

    state_t               state, state_n;
    logic [X_W+Y_W-1:0]   last_xy;
    logic [X_W+Y_W-1:0]   cur_xy;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 accept, issue_req, tmo;
    logic                 in_range, border, chk;
    logic [2:0]           bar_idx, bar_rgb;
    logic [COLOR_W-1:0]   bar_color, mode_color, color_n;
    int                   xi, yi;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        issue_req = 1'b0;
        tmo       = 1'b0;
        color_n   = VGA_COLOR;
        xi        = int'(VGA_X);
        yi        = int'(VGA_Y);
        cur_xy    = {VGA_X, VGA_Y};
        in_range  = (xi < H_ACTIVE) && (yi < V_ACTIVE);
`ifdef DESIM_BORDER_OVERLAY_EN
        border    = in_range && (xi == 0 || xi == H_ACTIVE - 1 || yi == 0 || yi == V_ACTIVE - 1);
`else
        border    = 1'b0;
`endif
        // Bar index counts thresholds passed; constants fold, no divider needed.
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xi >= k * BAR_W) bar_idx = bar_idx + 3'd1;
        end
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        bar_color = {{CH_W{bar_rgb[2]}}, {CH_W{bar_rgb[1]}}, {CH_W{bar_rgb[0]}}};
        chk = VGA_X[CHECK_SHIFT] ^ VGA_Y[CHECK_SHIFT];
        case (mode)
            2'd0:    mode_color = solid_color;
            2'd1:    mode_color = bar_color;
            2'd2:    mode_color = chk ? solid_color : '0;
            default: mode_color = '0;
        endcase

        case (state)
            IDLE: begin
                if (cur_xy != last_xy) begin
                    accept = 1'b1;
                    if (!in_range) begin
                        color_n = '0;
                        state_n = PLOT;
                    end else if (border) begin
                        color_n = BORDER_COLOR;
                        state_n = PLOT;
                    end else if (mode == 2'd3) begin
                        issue_req = 1'b1;
                        state_n   = WAIT;
                    end else begin
                        color_n = mode_color;
                        state_n = PLOT;
                    end
                end
            end
            WAIT: begin
                // A response on the final wait cycle still wins over the timeout.
                if (px_valid) begin
                    color_n = px_color;
                    state_n = PLOT;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    color_n = ERR_COLOR;
                    tmo     = 1'b1;
                    state_n = PLOT;
                end
            end
            PLOT:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            plot        <= 1'b0;
            busy        <= 1'b0;
            px_req      <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            VGA_COLOR   <= '0;
            timeout_err <= 1'b0;
            frame_count <= 8'd0;
            wait_cnt    <= '0;
            last_xy     <= '1;
        end else begin
            plot      <= (state == PLOT);
            busy      <= (state_n != IDLE);
            px_req    <= issue_req;
            VGA_COLOR <= color_n;
            wait_cnt  <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            if (issue_req) begin
                px_x <= VGA_X;
                px_y <= VGA_Y;
            end
            if (accept) last_xy <= cur_xy;
            if (tmo) timeout_err <= 1'b1;
            if (state == PLOT && last_xy == FRAME_END) frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_desim_pixel_painter.sv
// Directed bench for desim_pixel_painter: vector table for the colour modes plus
// hand-written handshake, timeout, out-of-range, frame-count and reset sequences.
module tb_desim_pixel_painter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [23:0] solid_color;
    logic [9:0]  VGA_X;
    logic [8:0]  VGA_Y;
    logic        px_req;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [23:0] px_color;
    logic        px_valid;
    logic [23:0] VGA_COLOR;
    logic        plot;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    desim_pixel_painter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .mode        (mode),
        .solid_color (solid_color),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .px_req      (px_req),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_color    (px_color),
        .px_valid    (px_valid),
        .VGA_COLOR   (VGA_COLOR),
        .plot        (plot),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] solid;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_plot(input int bound, output int lat);
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge CLOCK_50);
            if (plot) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic hold_quiet(input string name, input int n);
        int p;
        p = 0;
        repeat (n) begin
            @(negedge CLOCK_50);
            if (plot || px_req) p++;
        end
        check(name, 32'(p), 32'd0);
    endtask

    initial begin
        int lat;
        int reqs;
        vecs[0] = '{2'd0, 24'h00FF00, 10'd0,   9'd0,   24'h00FF00};
        vecs[1] = '{2'd1, 24'h000000, 10'd79,  9'd10,  24'hFFFFFF};
        vecs[2] = '{2'd1, 24'h000000, 10'd80,  9'd10,  24'hFFFF00};
        vecs[3] = '{2'd1, 24'h000000, 10'd639, 9'd10,  24'h000000};
        vecs[4] = '{2'd1, 24'h000000, 10'd160, 9'd10,  24'h00FFFF};
        vecs[5] = '{2'd1, 24'h000000, 10'd400, 9'd10,  24'hFF0000};
        vecs[6] = '{2'd2, 24'h123456, 10'd31,  9'd0,   24'h000000};
        vecs[7] = '{2'd2, 24'h123456, 10'd32,  9'd0,   24'h123456};
        vecs[8] = '{2'd2, 24'h123456, 10'd32,  9'd32,  24'h000000};
        vecs[9] = '{2'd0, 24'hFFFFFF, 10'd700, 9'd100, 24'h000000};

        reset = 1'b1; mode = 2'd0; solid_color = 24'h00FF00;
        VGA_X = '0; VGA_Y = '0; px_color = '0; px_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_plot",   32'(plot), 32'd0);
        check("rst_px_req", 32'(px_req), 32'd0);
        check("rst_color",  32'(VGA_COLOR), 32'd0);
        check("rst_px_x",   32'(px_x), 32'd0);
        check("rst_px_y",   32'(px_y), 32'd0);
        check("rst_tmo",    32'(timeout_err), 32'd0);
        check("rst_frame",  32'(frame_count), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            mode = vecs[v].mode; solid_color = vecs[v].solid;
            VGA_X = vecs[v].x; VGA_Y = vecs[v].y;
            wait_plot(10, lat);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
            check($sformatf("vec%0d_color", v), 32'(VGA_COLOR), 32'(vecs[v].exp));
            hold_quiet($sformatf("vec%0d_quiet", v), 3);
        end

        // Pass-through with a response three cycles after the request.
        mode = 2'd3; px_color = 24'hABCDEF; VGA_X = 10'd5; VGA_Y = 9'd7;
        @(negedge CLOCK_50);
        check("pt_req",  32'(px_req), 32'd1);
        check("pt_px_x", 32'(px_x), 32'd5);
        check("pt_px_y", 32'(px_y), 32'd7);
        check("pt_busy1", 32'(busy), 32'd1);
        @(negedge CLOCK_50);
        check("pt_req_once", 32'(px_req), 32'd0);
        check("pt_busy2", 32'(busy), 32'd1);
        @(negedge CLOCK_50);
        check("pt_busy3", 32'(busy), 32'd1);
        px_valid = 1'b1;
        @(negedge CLOCK_50);
        px_valid = 1'b0;
        check("pt_busy4", 32'(busy), 32'd1);
        check("pt_noplot_yet", 32'(plot), 32'd0);
        @(negedge CLOCK_50);
        check("pt_plot", 32'(plot), 32'd1);
        check("pt_color", 32'(VGA_COLOR), 32'hABCDEF);
        check("pt_busy_done", 32'(busy), 32'd0);
        hold_quiet("pt_quiet", 3);

        // Core never answers: timeout after 16 wait cycles.
        VGA_X = 10'd6;
        @(negedge CLOCK_50);
        check("to_req", 32'(px_req), 32'd1);
        check("to_tmo_clear", 32'(timeout_err), 32'd0);
        wait_plot(40, lat);
        check("to_latency", 32'(lat), 32'd17);
        check("to_color", 32'(VGA_COLOR), 32'hFF00FF);
        check("to_flag", 32'(timeout_err), 32'd1);
        px_valid = 1'b1; px_color = 24'h111111;
        hold_quiet("to_late_valid_ignored", 4);
        px_valid = 1'b0;
        check("to_flag_sticky", 32'(timeout_err), 32'd1);
        check("to_color_kept", 32'(VGA_COLOR), 32'hFF00FF);

        // Out of range in pass-through mode: no request, black.
        reqs = 0;
        VGA_X = 10'd700; VGA_Y = 9'd100;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLOCK_50);
            if (px_req) reqs++;
            if (plot) begin
                lat = i;
                break;
            end
        end
        check("oor_latency", 32'(lat), 32'd2);
        check("oor_no_req", 32'(reqs), 32'd0);
        check("oor_color", 32'(VGA_COLOR), 32'd0);
        hold_quiet("oor_quiet", 2);

        // Last visible pixel completes a frame.
        mode = 2'd0; solid_color = 24'h0000FF;
        check("frame_before", 32'(frame_count), 32'd0);
        VGA_X = 10'd639; VGA_Y = 9'd479;
        wait_plot(10, lat);
        check("frame_latency", 32'(lat), 32'd2);
        check("frame_color", 32'(VGA_COLOR), 32'h0000FF);
        check("frame_after", 32'(frame_count), 32'd1);
        hold_quiet("frame_quiet", 2);
        check("frame_once", 32'(frame_count), 32'd1);

        // Reset in the middle of a wait aborts the transaction.
        mode = 2'd3; VGA_X = 10'd10; VGA_Y = 9'd10;
        @(negedge CLOCK_50);
        check("rw_req", 32'(px_req), 32'd1);
        @(negedge CLOCK_50);
        px_valid = 1'b1; px_color = 24'h222222;
        reset = 1'b1;
        #1;
        check("rw_plot", 32'(plot), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_frame", 32'(frame_count), 32'd0);
        check("rw_tmo", 32'(timeout_err), 32'd0);
        check("rw_color", 32'(VGA_COLOR), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        check("rw_plot_held", 32'(plot), 32'd0);
        px_valid = 1'b0;
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rw_restart_req", 32'(px_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/desim_pixel_painter.md
Name: desim_pixel_painter

Overview:
Parametrised successor to the DESim top-level plot bridge. Watches the simulator's pixel coordinate stream and raises one plot pulse per new coordinate. Selects the pixel colour by mode: solid, colour bars, checkerboard, or pass-through from a VGA core over a request/valid handshake with timeout. Sits between the DESim pixel ports and the VGA core inside the board top.

Parameters:
X_W, 10, width of the x coordinate
Y_W, 9, width of the y coordinate
CH_W, 8, bits per colour channel; COLOR_W = 3*CH_W, packed {R,G,B}
H_ACTIVE, 640, visible width
V_ACTIVE, 480, visible height
CHECK_SHIFT, 5, checkerboard square size is 2^CHECK_SHIFT pixels
TIMEOUT, 16, maximum number of WAIT cycles for px_valid
ERR_COLOR, magenta (all-ones R and B, zero G), colour plotted on timeout
BORDER_COLOR, all-ones, colour used by the optional border overlay

Ports:
CLOCK_50 in 1 system clock; all logic on the rising edge
reset in 1 asynchronous, active-high reset
mode in 2 0=solid, 1=bars, 2=checker, 3=pass-through
solid_color in COLOR_W colour for modes 0 and 2
VGA_X in X_W DESim x coordinate
VGA_Y in Y_W DESim y coordinate
px_req out 1 one-cycle request to the core
px_x out X_W requested x
px_y out Y_W requested y
px_color in COLOR_W core colour, qualified by px_valid
px_valid in 1 core response strobe
VGA_COLOR out COLOR_W colour for DESim
plot out 1 one-cycle draw strobe
busy out 1 high whenever state is not IDLE
timeout_err out 1 sticky flag, set on any timeout
frame_count out 8 counts completed frames; wraps

Behaviour:
- Reset values:
  - Outputs: plot=0, px_req=0, VGA_COLOR=0, px_x=0, px_y=0, timeout_err=0, frame_count=0.
  - State: IDLE.
  - Last-accepted coordinate: all ones, so (0,0) after reset counts as new.
- Reset mid-operation: reset asserted in any state aborts the transaction immediately; a pending px_valid is discarded.
- All outputs are registered.
- FSM states: IDLE, WAIT, PLOT.
- IDLE:
  - A coordinate is new if {VGA_X,VGA_Y} differs from the last-accepted coordinate.
  - On a new coordinate: latch it as last-accepted and compute the colour.
  - In range (x<H_ACTIVE and y<V_ACTIVE), modes 0-2: load VGA_COLOR and go to PLOT.
  - Out of range, any mode: colour is black, go to PLOT, no request.
  - In range, mode 3: drive px_req=1 for exactly one cycle with px_x/px_y = coordinate, clear the wait counter, go to WAIT.
- WAIT:
  - px_valid=1: VGA_COLOR <= px_color, go to PLOT.
  - Otherwise the counter increments; after TIMEOUT cycles with no px_valid: VGA_COLOR <= ERR_COLOR, timeout_err <= 1, go to PLOT.
  - px_valid in the same cycle as the timeout is accepted as valid, not as a timeout.
- PLOT: plot=1 for exactly one cycle, then IDLE.
- px_valid outside WAIT is ignored.
- Latency:
  - Modes 0-2 and out-of-range: plot is high 2 cycles after the edge that samples the new coordinate (IDLE->PLOT edge, then plot registered).
  - Mode 3: plot is high 1 cycle after the edge that samples px_valid.
- Coordinates that change while busy are not queued. On return to IDLE the current input is compared with last-accepted, so only the latest coordinate is drawn and intermediate coordinates are dropped.
- mode and solid_color are sampled only in IDLE when a coordinate is accepted.
- Bars (mode 1):
  - Bar index = count of k in 1..7 with x >= k*(H_ACTIVE/8), using elaboration-time constants and no divider.
  - Colours in index order: white, yellow, cyan, green, magenta, red, blue, black.
  - "On" channels are all-ones CH_W.
- Checker (mode 2): solid_color if bit 0 of ((x>>CHECK_SHIFT) ^ (y>>CHECK_SHIFT)) is 1, else black.
- frame_count increments, wrapping 255->0, on the plot of coordinate (H_ACTIVE-1, V_ACTIVE-1).

Optional Feature:
- Macro: DESIM_BORDER_OVERLAY_EN.
- Defined: any in-range pixel with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 plots BORDER_COLOR in every mode. In mode 3 these pixels issue no px_req and go straight to PLOT.
- Undefined: no overlay logic; border pixels follow the normal mode rules.

Test Plan:
- Reset, mode 0, solid_color=24'h00FF00, drive (0,0) -> one plot pulse 2 cycles later with VGA_COLOR=24'h00FF00; holding (0,0) produces no further pulses.
- Mode 1, x=79 then x=80 then x=639, y=10 -> colours FFFFFF, FFFF00, 000000; one plot per coordinate.
- Mode 2, CHECK_SHIFT=5, solid_color=24'h123456, (31,0), (32,0), (32,32) -> 000000, 123456, 000000.
- Mode 3, (5,7): core returns px_valid with 24'hABCDEF 3 cycles after px_req -> px_x=5, px_y=7, one px_req, plot with ABCDEF, busy high throughout.
- Mode 3, core never responds -> plot after 16 WAIT cycles with ERR_COLOR, timeout_err=1 and stays set; a later px_valid is ignored.
- Out-of-range (700,100) in mode 3 -> no px_req, plot with black; stepping through (639,479) -> frame_count 0->1; reset asserted mid-WAIT -> plot=0, busy=0, frame_count=0.
